// File: rtl/ldpc_err_mask_gen_if.sv
// Control/status bundle of the LDPC channel-error mask generator.
// master = stimulus/consumer side, slave = the generator itself.
interface ldpc_err_mask_gen_if #(
  parameter int unsigned NN    = 208,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned FRM_W = 16
);
  logic             clr;
  logic             seed_load;
  logic [31:0]      seed;
  logic             gen_start;
  logic [31:0]      prob_thresh;
  logic [CNT_W-1:0] max_errs;
  logic             mask_ready;
  logic             busy;
  logic             mask_valid;
  logic [NN-1:0]    mask;
  logic [CNT_W-1:0] err_count;
  logic [FRM_W-1:0] frames_done;

  modport master (
    output clr, seed_load, seed, gen_start, prob_thresh, max_errs, mask_ready,
    input  busy, mask_valid, mask, err_count, frames_done
  );

  modport slave (
    input  clr, seed_load, seed, gen_start, prob_thresh, max_errs, mask_ready,
    output busy, mask_valid, mask, err_count, frames_done
  );
endinterface

// File: rtl/ldpc_err_mask_gen.sv
// Builds an NN-bit channel-error mask one bit per cycle from a 32-bit Galois
// LFSR, with a per-bit flip threshold and an optional error cap.
module ldpc_err_mask_gen #(
  parameter int unsigned NN    = 208,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned FRM_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  ldpc_err_mask_gen_if.slave bus
);

  localparam int unsigned IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NN-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frm_q, frm_d;

  logic [31:0] lfsr_step;
  logic        hit;

  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : '0);
  assign hit = (lfsr_q <= bus.prob_thresh) &&
               ((bus.max_errs == '0) || (cnt_q < bus.max_errs));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    // clr keeps the LFSR sequence and frame count, drops everything else
    if (bus.clr) begin
      state_d = IDLE;
      idx_d   = '0;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.seed_load)
            lfsr_d = (bus.seed == '0) ? 32'h0000_0001 : bus.seed;
          if (bus.gen_start) begin
            mask_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = GEN;
          end
        end
        GEN: begin
          mask_d[idx_q] = hit;
          cnt_d         = cnt_q + CNT_W'(hit);
          lfsr_d        = lfsr_step;
          idx_d         = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NN - 1))
            state_d = HOLD;
        end
        HOLD: begin
          if (bus.mask_ready) begin
            frm_d   = frm_q + FRM_W'(1);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lfsr_q  <= 32'h0000_0001;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
    end
  end

  assign bus.busy        = (state_q == GEN) || (state_q == HOLD);
  assign bus.mask_valid  = (state_q == HOLD);
  assign bus.mask        = mask_q;
  assign bus.err_count   = cnt_q;
  assign bus.frames_done = frm_q;

endmodule

// File: doc/ldpc_err_mask_gen.md
Name: ldpc_err_mask_gen

Overview:
- Channel-error stage that sits directly upstream of the LDPC decoder wrapper.
- Builds an NN-bit error mask one bit per cycle from a seeded 32-bit Galois LFSR, using a programmable per-bit flip probability and an optional cap on the number of errors.
- Hands the finished mask over a valid/ready handshake; the top level XORs it into the codeword as err_intro_q0_1_frmC.

Parameters:
- NN, 208, codeword length in bits; equals the mask width.
- CNT_W, 8, width of the error counter; must satisfy 2^CNT_W > NN.
- FRM_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft clear.
- seed_load  in  1  loads seed into the LFSR; acted on only in IDLE.
- seed  in  32  LFSR seed value.
- gen_start  in  1  starts one mask generation; acted on only in IDLE.
- prob_thresh  in  32  a mask bit is set when the current LFSR value <= prob_thresh.
- max_errs  in  CNT_W  cap on set bits per mask; 0 means no cap.
- mask_ready  in  1  consumer accepts the mask.
- busy  out  1  high in GEN or HOLD.
- mask_valid  out  1  high in HOLD.
- mask  out  NN  error mask.
- err_count  out  CNT_W  number of set bits in mask.
- frames_done  out  FRM_W  count of accepted masks; wraps.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, lfsr=32'h0000_0001, bit index=0.
  - mask=0, err_count=0, frames_done=0, busy=0, mask_valid=0.
- LFSR step: next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 0).
  - The LFSR advances only in GEN, once per cycle.
  - The LFSR is never zero. A seed_load with seed=0 loads 32'h0000_0001.
- IDLE:
  - If seed_load=1, lfsr<=seed (or 1 when seed=0).
  - If gen_start=1: mask<=0, err_count<=0, index<=0, go to GEN.
  - If seed_load and gen_start arrive in the same cycle, the first GEN bit uses the newly loaded seed.
- GEN (exactly NN cycles, index 0..NN-1):
  - hit = (lfsr <= prob_thresh) && (max_errs==0 || err_count < max_errs).
  - mask[index]<=hit, err_count<=err_count+hit, advance LFSR, index<=index+1.
  - mask[0] is decided in the first GEN cycle.
  - After index NN-1, go to HOLD.
  - prob_thresh=0 yields no hits because the LFSR is >=1. prob_thresh=32'hFFFF_FFFF yields a hit on every bit until the cap.
- HOLD:
  - mask_valid=1; mask and err_count stay stable.
  - On mask_valid && mask_ready: frames_done<=frames_done+1 (wraps at 2^FRM_W), go to IDLE.
  - mask and err_count keep their values in IDLE until the next gen_start.
- Latency: gen_start sampled in IDLE at edge t gives GEN at cycles t+1..t+NN and mask_valid=1 from cycle t+NN+1.
  - Earliest next gen_start is the cycle after the handshake.
- Ignored inputs:
  - gen_start and seed_load outside IDLE.
  - prob_thresh and max_errs are sampled live every GEN cycle; callers must hold them stable during GEN.
- clr=1 (synchronous, any state, priority over everything except reset):
  - state=IDLE, index=0, mask=0, err_count=0, mask_valid=0, busy=0.
  - lfsr and frames_done are kept.
- Reset during GEN or HOLD aborts immediately to the reset values above; no partial mask stays visible.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, prob_thresh=0, pulse gen_start -> busy=1 next cycle; mask_valid rises exactly 209 cycles after the gen_start edge; mask=0, err_count=0; with mask_ready=1, frames_done=1.
- prob_thresh=32'hFFFF_FFFF, max_errs=0 -> mask = all 208 ones, err_count=208 (8'hD0).
- prob_thresh=32'hFFFF_FFFF, max_errs=5 -> mask=208'h1F (bits 0..4 set), err_count=5.
- seed_load seed=32'h1 with prob_thresh=32'h8000_0000, generate; repeat with the same seed -> identical masks, mask[0]=1. seed_load with seed=0 -> same mask as seed=1.
- Hold mask_ready=0 for 10 cycles in HOLD and pulse gen_start and seed_load -> mask, err_count and mask_valid stay unchanged, no new generation. Raise mask_ready -> single handshake, frames_done increments by exactly 1, state returns to IDLE.
- Cover both abort paths:
  - Assert clr at GEN index 50 -> IDLE next cycle, mask=0, frames_done unchanged.
  - Drop rstn mid-GEN -> outputs clear asynchronously, and the next generation matches one started from lfsr=1.
